vedio_ser: RTL
==============

Name: vedio_ser

Overview:
Video serializer. Inverse of the capture path.
- Takes the capture-format pixel stream: 24-bit RGB888 words, one word valid every SRC_CHN clocks while cap_hsync is high.
- Emits the camera/source-format byte stream: one SRC_DW-bit channel per clock, with src_hsync/src_vsync aligned to the bytes.
- Sits between image-processing output and any consumer that expects a raw 8-bit sensor-style interface. It is also used to loop processed frames back into the capture path for round-trip simulation.

Parameters:
IW, 640, image width in pixels
IH, 480, image height in lines
SRC_DW, 8, output byte width
SRC_CHN, 3, channels per pixel (1..4)
CAP_DW, 24, input pixel width; must equal SRC_DW*SRC_CHN
MSB_FIRST, 1, 1: emit cap_data[CAP_DW-1 -: SRC_DW] first; 0: emit the LSB channel first

Ports:
src_pclk  input  1  pixel/byte clock, single clock domain
rst_n  input  1  asynchronous active-low reset
cap_hsync  input  1  input line-active flag
cap_vsync  input  1  input frame sync
cap_valid  input  1  pixel strobe, one cycle per pixel
cap_data  input  CAP_DW  pixel word, sampled when cap_valid & cap_hsync
src_hsync  output  1  output line-active flag
src_vsync  output  1  output frame sync
src_data_out  output  SRC_DW  serialized channel byte
frame_done  output  1  one-cycle pulse after the last byte of line IH-1
err_flag  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- One clock, src_pclk. Reset is asynchronous and active-low on rst_n. All outputs and internal state reset to 0.
- Reset asserted mid-line aborts immediately. After release, output resumes at the next cap_vsync rising edge; src_hsync re-follows cap_hsync one cycle later.
- Latency is fixed at 1 clock:
  - src_hsync = cap_hsync registered once; src_vsync = cap_vsync registered once.
  - Pixel accepted at cycle t → bytes appear at t+1 .. t+SRC_CHN.
- Load: cap_valid & cap_hsync → shift register <= cap_data, channel counter cnt_ch <= 0, src_data_out <= first channel (per MSB_FIRST).
- Shift: when cnt_ch < SRC_CHN-1 and no load, cnt_ch++ and src_data_out <= next channel.
- Nominal cadence: valid at t, t+SRC_CHN, … gives gap-free bytes for the whole line.
- src_data_out is 0 whenever the registered hsync is low. It is also 0 after the last channel if no new valid arrives (underrun); src_hsync stays as registered.
- Early valid (cnt_ch ≠ SRC_CHN-1): new pixel wins. Remaining bytes of the old pixel are dropped and the cadence error is raised.
- cap_valid with cap_hsync low is ignored.
- Counters:
  - Pixel counter x (0..IW-1) increments per accepted pixel.
  - cap_hsync falling edge → x <= 0, cnt_ch <= SRC_CHN-1 (idle); line counter y increments, wrapping IH-1 → 0.
  - cap_vsync rising edge → x <= 0, y <= 0. It takes priority over a simultaneous hsync fall.
- frame_done pulses on the cycle after the last byte of line IH-1 is emitted. This is the cycle src_hsync falls with y == IH-1.
- SRC_CHN = 1 degenerates to a 1-cycle register: data passes through with sync aligned.

Optional Feature:
Macro VEDIO_SER_CHK_EN.
- Defined: protocol checker is built in. err_flag is set (sticky until rst_n) when any of these occurs:
  - Early valid.
  - Underrun inside a line, i.e. the missing valid at expected cycle t+SRC_CHN.
  - Line length x ≠ IW at the cap_hsync fall.
  - Line count ≠ IH at a cap_vsync rise, excluding the first frame after reset.
- Not defined: checker logic is absent and err_flag is tied to 0. Data-path behaviour is identical either way.

Decomposition:
- Shared package vedio_pkg: IW, IH, SRC_DW, SRC_CHN, CAP_DW defaults, plus clog2-based counter widths for x, y and cnt_ch. Shared with the capture and generator blocks.
- One natural sub-module: vedio_ser_chk, holding the checker counters and err_flag. It is instantiated only under VEDIO_SER_CHK_EN.

Test Plan:
- IW=4, IH=2, pixels 0xA1B2C3, 0xD4E5F6, …, valid every 3 clocks, MSB_FIRST=1 → bytes A1,B2,C3,D4,E5,F6… gap-free from t+1; src_hsync high for exactly 12 cycles per line; err_flag=0.
- Same stimulus with MSB_FIRST=0 → C3,B2,A1,F6,E5,D4; timing unchanged.
- Two full frames → frame_done pulses once per frame, on the src_hsync fall of line 1. A cap_vsync rise resets y; the second frame's first byte is A1 again.
- Valid arriving 2 clocks after the previous one → old pixel truncated to 2 bytes, new pixel emitted in full; err_flag=1 only with the macro defined.
- Drop one valid mid-line → 3 zero bytes with src_hsync high. Line of 3 pixels with IW=4 → err_flag=1 (macro on), 0 (macro off).
- rst_n pulsed low mid-line → all outputs 0 asynchronously. After release, output restarts cleanly at the next frame; round-trip through the capture block reproduces the original 24-bit pixels.

Source files
------------

// File: rtl/vedio_pkg.sv
// Shared defaults for the video capture/serializer/generator blocks.
// Counter widths are derived with cnt_w() so every block sizes x, y and cnt_ch the same way.
package vedio_pkg;

  localparam int IW_DEF      = 640;
  localparam int IH_DEF      = 480;
  localparam int SRC_DW_DEF  = 8;
  localparam int SRC_CHN_DEF = 3;
  localparam int CAP_DW_DEF  = SRC_DW_DEF * SRC_CHN_DEF;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W_DEF  = cnt_w(IW_DEF + 1);
  localparam int Y_W_DEF  = cnt_w(IH_DEF);
  localparam int CH_W_DEF = cnt_w(SRC_CHN_DEF);

endpackage

// File: rtl/vedio_ser_if.sv
// Pixel-in / byte-out stream bundle of the video serializer.
interface vedio_ser_if #(
  parameter int SRC_DW = vedio_pkg::SRC_DW_DEF,
  parameter int CAP_DW = vedio_pkg::CAP_DW_DEF
);

  // No back-pressure: a pixel is taken on every src_pclk edge where cap_valid and
  // cap_hsync are both high; the byte side is a free-running one-byte-per-clock stream.
  logic              cap_hsync;
  logic              cap_vsync;
  logic              cap_valid;
  logic [CAP_DW-1:0] cap_data;
  logic              src_hsync;
  logic              src_vsync;
  logic [SRC_DW-1:0] src_data_out;

  modport master (
    output cap_hsync, cap_vsync, cap_valid, cap_data,
    input  src_hsync, src_vsync, src_data_out
  );

  modport slave (
    input  cap_hsync, cap_vsync, cap_valid, cap_data,
    output src_hsync, src_vsync, src_data_out
  );

endinterface

// File: rtl/vedio_ser_chk.sv
// Protocol checker for vedio_ser: early valid, underrun, line length and line count errors.
// Only instantiated when VEDIO_SER_CHK_EN is defined.
module vedio_ser_chk
  import vedio_pkg::*;
#(
  parameter int IW      = IW_DEF,
  parameter int IH      = IH_DEF,
  parameter int SRC_CHN = SRC_CHN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic line_act,
  input  logic hs_fall,
  input  logic vs_rise,
  output logic err_flag
);

  localparam int GW = cnt_w(SRC_CHN);
  localparam int XW = cnt_w(IW + 1);
  localparam int LW = cnt_w(IH + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SRC_CHN - 1);

  logic [GW-1:0] gap;
  logic          pend;
  logic [XW-1:0] x;
  logic [LW-1:0] lines;
  logic          seen;
  logic          early, underrun, bad_len, bad_cnt;

  // gap counts clocks since the last accepted pixel; the next one is due when gap hits GAP_LAST.
  assign early    = load & pend & (gap < GAP_LAST);
  assign underrun = line_act & ~load & pend & (gap == GAP_LAST);
  assign bad_len  = hs_fall & (x != XW'(IW));
  assign bad_cnt  = vs_rise & seen & (lines != LW'(IH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap      <= '0;
      pend     <= 1'b0;
      x        <= '0;
      lines    <= '0;
      seen     <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      err_flag <= err_flag | early | underrun | bad_len | bad_cnt;

      if (load) begin
        pend <= 1'b1;
        gap  <= '0;
      end else if (hs_fall || vs_rise || underrun) begin
        pend <= 1'b0;
      end else if (gap < GAP_LAST) begin
        gap <= gap + 1'b1;
      end

      if (vs_rise || hs_fall) begin
        x <= '0;
      end else if (load && x != XW'(IW)) begin
        x <= x + 1'b1;
      end

      if (vs_rise) begin
        lines <= '0;
        seen  <= 1'b1;
      end else if (hs_fall && lines != {LW{1'b1}}) begin
        lines <= lines + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vedio_ser.sv
// Video serializer: RGB pixel words in, one channel byte per clock out, syncs delayed by one clock.
// Optional protocol checker is built when VEDIO_SER_CHK_EN is defined; otherwise err_flag is 0.
module vedio_ser
  import vedio_pkg::*;
#(
  parameter int IW        = IW_DEF,
  parameter int IH        = IH_DEF,
  parameter int SRC_DW    = SRC_DW_DEF,
  parameter int SRC_CHN   = SRC_CHN_DEF,
  parameter int CAP_DW    = CAP_DW_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic        src_pclk,
  input  logic        rst_n,
  vedio_ser_if.slave  bus,
  output logic        frame_done,
  output logic        err_flag
);

  localparam int CW = cnt_w(SRC_CHN);
  localparam int YW = cnt_w(IH);
  localparam logic [CW-1:0] CH_LAST = CW'(SRC_CHN - 1);

  if (CAP_DW != SRC_DW * SRC_CHN || SRC_CHN < 1 || SRC_CHN > 4 || IW < 1 || IH < 1) begin : g_cfg_err
    $error("vedio_ser: inconsistent parameter set");
  end

  logic              cap_hs_d;
  logic              cap_vs_d;
  logic              active;
  logic [CAP_DW-1:0] shreg;
  logic [CW-1:0]     cnt_ch;
  logic [YW-1:0]     y;
  logic              vs_rise, hs_fall, run, load;

  // After reset nothing is emitted until the first frame start; the rising edge itself counts.
  assign vs_rise = bus.cap_vsync & ~cap_vs_d;
  assign hs_fall = ~bus.cap_hsync & cap_hs_d;
  assign run     = active | vs_rise;
  assign load    = run & bus.cap_hsync & bus.cap_valid;

  function automatic logic [SRC_DW-1:0] chan(input logic [CAP_DW-1:0] w, input int k);
    logic [CAP_DW-1:0] t;
    int                idx;
    idx = (MSB_FIRST != 0) ? (SRC_CHN - 1 - k) : k;
    t   = w >> (idx * SRC_DW);
    return t[SRC_DW-1:0];
  endfunction

  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cap_hs_d         <= 1'b0;
      cap_vs_d         <= 1'b0;
      active           <= 1'b0;
      shreg            <= '0;
      cnt_ch           <= '0;
      y                <= '0;
      frame_done       <= 1'b0;
      bus.src_hsync    <= 1'b0;
      bus.src_vsync    <= 1'b0;
      bus.src_data_out <= '0;
    end else begin
      cap_hs_d      <= bus.cap_hsync;
      cap_vs_d      <= bus.cap_vsync;
      bus.src_vsync <= bus.cap_vsync;
      bus.src_hsync <= bus.cap_hsync & run;
      if (vs_rise) active <= 1'b1;

      // The output hsync falls on the cycle after hs_fall, which is exactly when this pulses.
      frame_done <= run & hs_fall & ~vs_rise & (y == YW'(IH - 1));

      // A new pixel always wins, even if the previous one still has bytes left.
      if (load) begin
        shreg            <= bus.cap_data;
        cnt_ch           <= '0;
        bus.src_data_out <= chan(bus.cap_data, 0);
      end else if (!bus.cap_hsync || !run) begin
        cnt_ch           <= CH_LAST;
        bus.src_data_out <= '0;
      end else if (cnt_ch < CH_LAST) begin
        cnt_ch           <= cnt_ch + 1'b1;
        bus.src_data_out <= chan(shreg, int'(cnt_ch) + 1);
      end else begin
        bus.src_data_out <= '0;
      end

      if (vs_rise) begin
        y <= '0;
      end else if (run && hs_fall) begin
        y <= (y == YW'(IH - 1)) ? '0 : y + 1'b1;
      end
    end
  end

`ifdef VEDIO_SER_CHK_EN
  vedio_ser_chk #(
    .IW      (IW),
    .IH      (IH),
    .SRC_CHN (SRC_CHN)
  ) u_chk (
    .clk      (src_pclk),
    .rst_n    (rst_n),
    .load     (load),
    .line_act (run & bus.cap_hsync),
    .hs_fall  (run & hs_fall & ~vs_rise),
    .vs_rise  (vs_rise),
    .err_flag (err_flag)
  );
`else
  assign err_flag = 1'b0;
`endif

endmodule
